// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared constants and types for the fetch stage and the pipeline
//   registers downstream of it.
//   - PC_RESET / IM_BASE / IM_WORDS : default fetch-address map
//   - NOP_WORD                      : instruction injected for bubbles and bad fetches
//   - fd_bundle_t / FD_W            : F/D slot layout, reused by the D/E register
//   - FD_BUBBLE                     : value an emptied F/D slot takes
//   - pc_illegal()                  : fetch-address legality test
package fetch_stage_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INSTR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_RESET = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] IM_BASE  = 32'h0000_3000;
  localparam int unsigned       IM_WORDS = 4096;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  localparam logic [ADDR_W-1:0]  BUBBLE_PC    = '0;
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR = NOP_WORD;
  localparam logic               BUBBLE_VALID = 1'b0;
  localparam logic               BUBBLE_EXC   = 1'b0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
    logic               exc_adel;
  } fd_bundle_t;

  localparam int unsigned FD_W = $bits(fd_bundle_t);

  localparam fd_bundle_t FD_BUBBLE = '{
    pc:       BUBBLE_PC,
    instr:    BUBBLE_INSTR,
    valid:    BUBBLE_VALID,
    exc_adel: BUBBLE_EXC
  };

  // Last legal word address for a memory of `words` words starting at `base`.
  function automatic logic [ADDR_W-1:0] im_last(input logic [ADDR_W-1:0] base,
                                                input int unsigned       words);
    return base + ADDR_W'(4 * words) - ADDR_W'(4);
  endfunction

  // A fetch is illegal when misaligned or outside [base, last].
  function automatic logic pc_illegal(input logic [ADDR_W-1:0] pc,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] last);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > last);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Instruction-memory read bus between the fetch stage and the I-memory.
//   - im_addr  : word address driven by fetch (master)
//   - im_rdata : instruction word, combinational from im_addr (slave)
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_rdata;

  modport master (output im_addr, input  im_rdata);
  modport slave  (input  im_addr, output im_rdata);
endinterface

// File: rtl/fetch_stage_fd_reg.sv
// fd_reg
//   Generic pipeline register used between stages (F/D, D/E, E/M, M/W).
//   - clk    : rising-edge clock
//   - rst_n  : synchronous active-low reset, loads BUBBLE
//   - en_i   : capture d_i when high (driven by ~stall)
//   - clr_i  : load BUBBLE; overrides en_i (driven by flush)
//   - d_i    : next slot contents
//   - q_o    : registered slot contents
module fd_reg #(
  parameter int unsigned      WIDTH  = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] slot_q;
  logic [WIDTH-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = BUBBLE;
    end else if (en_i) begin
      slot_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= BUBBLE;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   MIPS fetch stage plus the F/D pipeline register feeding decode.
//   Owns the PC, drives the instruction-memory address, applies
//   flush / stall / branch-jump redirect (one delay slot) and flags
//   illegal fetch addresses so the exception rides with the D slot.
//   - clk, reset      : rising-edge clock, synchronous active-low reset
//   - stall           : hold PC and F/D
//   - redirect        : D-stage branch/jump target valid in redirect_pc
//   - flush, flush_pc : empty F/D and restart fetch at flush_pc
//   - im              : instruction-memory bus (master side)
//   - F_pc, F_instruction : current fetch slot (trace / next D contents)
//   - D_pc, D_instruction, D_valid, D_exc_adel : registered slot for decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET = fetch_stage_pkg::PC_RESET,
  parameter logic [ADDR_W-1:0] IM_BASE  = fetch_stage_pkg::IM_BASE,
  parameter int unsigned       IM_WORDS = fetch_stage_pkg::IM_WORDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  fetch_stage_if.master      im,
  output logic [ADDR_W-1:0]  F_pc,
  output logic [INSTR_W-1:0] F_instruction,
  output logic [ADDR_W-1:0]  D_pc,
  output logic [INSTR_W-1:0] D_instruction,
  output logic               D_valid,
  output logic               D_exc_adel
);

  localparam logic [ADDR_W-1:0] IM_LAST = im_last(IM_BASE, IM_WORDS);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              f_illegal;
  fd_bundle_t        fd_d;
  fd_bundle_t        fd_q;

  assign f_illegal     = pc_illegal(pc_q, IM_BASE, IM_LAST);
  assign im.im_addr    = pc_q;
  assign F_pc          = pc_q;
  // The memory word is masked, never forwarded, when the address is bad.
  assign F_instruction = f_illegal ? NOP_WORD : im.im_rdata;

  // Redirect is examined only after stall so stale targets are dropped
  // while the hazard unit holds the pipe.
  always_comb begin
    pc_d = pc_q + ADDR_W'(4);
    if (flush) begin
      pc_d = flush_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  // On redirect the current F slot is the delay slot and is captured
  // exactly like a sequential fetch.
  always_comb begin
    fd_d          = FD_BUBBLE;
    fd_d.pc       = pc_q;
    fd_d.instr    = F_instruction;
    fd_d.valid    = 1'b1;
    fd_d.exc_adel = f_illegal;
  end

  fd_reg #(
    .WIDTH  (FD_W),
    .BUBBLE (FD_BUBBLE)
  ) u_fd_reg (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (~stall),
    .clr_i (flush),
    .d_i   (fd_d),
    .q_o   (fd_q)
  );

  assign D_pc          = fd_q.pc;
  assign D_instruction = fd_q.instr;
  assign D_valid       = fd_q.valid;
  assign D_exc_adel    = fd_q.exc_adel;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] TAG      = 32'hA5A5_0000;
  localparam logic [31:0] PC_RST   = 32'h0000_3000;
  localparam logic [31:0] BASE     = 32'h0000_3000;
  localparam logic [31:0] LAST     = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] F_pc, F_instruction, D_pc, D_instruction;
  logic        D_valid, D_exc_adel;

  fetch_stage_if imif ();
  // Address-tagged instruction memory.
  assign imif.im_rdata = imif.im_addr ^ TAG;

  fetch_stage #(
    .PC_RESET (32'h0000_3000),
    .IM_BASE  (32'h0000_3000),
    .IM_WORDS (4096)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .im            (imif.master),
    .F_pc          (F_pc),
    .F_instruction (F_instruction),
    .D_pc          (D_pc),
    .D_instruction (D_instruction),
    .D_valid       (D_valid),
    .D_exc_adel    (D_exc_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [31:0] dinstr;
    logic        valid;
    logic        exc;
  } exp_t;

  // rst is active-low: 0 = reset this edge.
  typedef struct {
    logic        rst;
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        fl;
    logic [31:0] fpc;
  } vec_t;

  exp_t sb[$];
  exp_t m;            // model of the architectural state
  int   checks = 0;
  int   errors = 0;

  function automatic logic ill(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < BASE) || (pc > LAST);
  endfunction

  function automatic logic [31:0] finstr(input logic [31:0] pc);
    return ill(pc) ? 32'h0 : (pc ^ TAG);
  endfunction

  // Drive one edge's inputs, predict the post-edge state, push it, clock.
  task automatic cyc(input vec_t v);
    exp_t e;
    reset = v.rst; stall = v.st; redirect = v.rd; redirect_pc = v.rpc;
    flush = v.fl;  flush_pc = v.fpc;
    e = m;
    if (!v.rst) begin
      e.fpc = PC_RST; e.dpc = 0; e.dinstr = 0; e.valid = 0; e.exc = 0;
    end else if (v.fl) begin
      e.fpc = v.fpc;  e.dpc = 0; e.dinstr = 0; e.valid = 0; e.exc = 0;
    end else if (!v.st) begin
      e.dpc    = m.fpc;
      e.dinstr = finstr(m.fpc);
      e.valid  = 1'b1;
      e.exc    = ill(m.fpc);
      e.fpc    = v.rd ? v.rpc : m.fpc + 32'd4;
    end
    m = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t run();
    return '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
  endfunction
  function automatic vec_t rst_v();
    return '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
  endfunction
  function automatic vec_t stl();
    return '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
  endfunction
  function automatic vec_t redir(input logic [31:0] pc);
    return '{1'b1, 1'b0, 1'b1, pc, 1'b0, 32'h0};
  endfunction

  task automatic test_reset();
    vec_t v[$];
    exp_t e;
    v = '{rst_v(), rst_v(), run(), run()};
    foreach (v[i]) begin
      cyc(v[i]);
      e = sb.pop_front();
      checks++;
      if ({F_pc, F_instruction, D_pc, D_instruction, D_valid, D_exc_adel} !==
          {e.fpc, finstr(e.fpc), e.dpc, e.dinstr, e.valid, e.exc}) begin
        errors++;
        $display("FAIL reset_run[%0d]: got F_pc=%h F_ins=%h D_pc=%h D_ins=%h v=%b x=%b, want F_pc=%h F_ins=%h D_pc=%h D_ins=%h v=%b x=%b",
                 i, F_pc, F_instruction, D_pc, D_instruction, D_valid, D_exc_adel,
                 e.fpc, finstr(e.fpc), e.dpc, e.dinstr, e.valid, e.exc);
      end
    end
  endtask

  task automatic test_stall();
    vec_t v[$];
    exp_t e;
    v = '{stl(), stl(), run(), run()};
    foreach (v[i]) begin
      cyc(v[i]);
      e = sb.pop_front();
      checks++;
      if ({F_pc, F_instruction, D_pc, D_instruction, D_valid, D_exc_adel} !==
          {e.fpc, finstr(e.fpc), e.dpc, e.dinstr, e.valid, e.exc}) begin
        errors++;
        $display("FAIL stall[%0d]: got F_pc=%h D_pc=%h D_ins=%h v=%b x=%b, want F_pc=%h D_pc=%h D_ins=%h v=%b x=%b",
                 i, F_pc, D_pc, D_instruction, D_valid, D_exc_adel,
                 e.fpc, e.dpc, e.dinstr, e.valid, e.exc);
      end
    end
  endtask

  task automatic test_redirect();
    vec_t v[$];
    vec_t sr;
    exp_t e;
    sr = redir(32'h0000_3200);
    sr.st = 1'b1;
    // delay-slot redirect, then stall+redirect held, then redirect alone
    v = '{redir(32'h0000_3100), run(), sr, redir(32'h0000_3200), run()};
    foreach (v[i]) begin
      cyc(v[i]);
      e = sb.pop_front();
      checks++;
      if ({F_pc, F_instruction, D_pc, D_instruction, D_valid, D_exc_adel} !==
          {e.fpc, finstr(e.fpc), e.dpc, e.dinstr, e.valid, e.exc}) begin
        errors++;
        $display("FAIL redirect[%0d]: got F_pc=%h D_pc=%h D_ins=%h v=%b x=%b, want F_pc=%h D_pc=%h D_ins=%h v=%b x=%b",
                 i, F_pc, D_pc, D_instruction, D_valid, D_exc_adel,
                 e.fpc, e.dpc, e.dinstr, e.valid, e.exc);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t v[$];
    exp_t e;
    v = '{redir(32'h0000_3002), run(),
          redir(32'h0000_2FFC), run(),
          redir(32'h0000_7000), run(),
          redir(32'h0000_6FFC), run(), run(),
          redir(32'h0000_3000), run(),
          redir(32'hFFFF_FFFC), run(), run()};
    foreach (v[i]) begin
      cyc(v[i]);
      e = sb.pop_front();
      checks++;
      if ({F_pc, F_instruction, D_pc, D_instruction, D_valid, D_exc_adel} !==
          {e.fpc, finstr(e.fpc), e.dpc, e.dinstr, e.valid, e.exc}) begin
        errors++;
        $display("FAIL illegal[%0d]: got F_pc=%h F_ins=%h D_pc=%h D_ins=%h v=%b x=%b, want F_pc=%h F_ins=%h D_pc=%h D_ins=%h v=%b x=%b",
                 i, F_pc, F_instruction, D_pc, D_instruction, D_valid, D_exc_adel,
                 e.fpc, finstr(e.fpc), e.dpc, e.dinstr, e.valid, e.exc);
      end
    end
  endtask

  task automatic test_flush();
    vec_t v[$];
    vec_t all, rs;
    exp_t e;
    all = '{1'b1, 1'b1, 1'b1, 32'h0000_3300, 1'b1, 32'h0000_4180};
    rs  = '{1'b0, 1'b1, 1'b1, 32'h0000_3300, 1'b0, 32'h0};
    v = '{run(), all, run(), run(), stl(), rs, run(), run()};
    foreach (v[i]) begin
      cyc(v[i]);
      e = sb.pop_front();
      checks++;
      if ({F_pc, F_instruction, D_pc, D_instruction, D_valid, D_exc_adel} !==
          {e.fpc, finstr(e.fpc), e.dpc, e.dinstr, e.valid, e.exc}) begin
        errors++;
        $display("FAIL flush_reset[%0d]: got F_pc=%h D_pc=%h D_ins=%h v=%b x=%b, want F_pc=%h D_pc=%h D_ins=%h v=%b x=%b",
                 i, F_pc, D_pc, D_instruction, D_valid, D_exc_adel,
                 e.fpc, e.dpc, e.dinstr, e.valid, e.exc);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    for (int unsigned k = 0; k < 12; k++) begin
      vec_t r;
      r = run();
      r.st = ($urandom_range(0, 3) == 0);
      r.rd = ($urandom_range(0, 3) == 0);
      r.rpc = 32'h0000_3000 + (32'($urandom_range(0, 64)) << 2);
      v.push_back(r);
    end
    foreach (v[i]) begin
      cyc(v[i]);
      e = sb.pop_front();
      checks++;
      if ({F_pc, F_instruction, D_pc, D_instruction, D_valid, D_exc_adel} !==
          {e.fpc, finstr(e.fpc), e.dpc, e.dinstr, e.valid, e.exc}) begin
        errors++;
        $display("FAIL b2b[%0d]: got F_pc=%h D_pc=%h D_ins=%h v=%b x=%b, want F_pc=%h D_pc=%h D_ins=%h v=%b x=%b",
                 i, F_pc, D_pc, D_instruction, D_valid, D_exc_adel,
                 e.fpc, e.dpc, e.dinstr, e.valid, e.exc);
      end
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    flush = 1'b0; flush_pc = '0;
    m = '{PC_RST, 32'h0, 32'h0, 1'b0, 1'b0};
    @(negedge clk);
    test_reset();
    test_stall();
    test_redirect();
    test_illegal();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch (F) stage plus F/D pipeline register of the five-stage MIPS core; sits directly upstream of decode.
- Owns the PC and drives the instruction-memory address.
- Applies hazard-unit stall, D-stage branch/jump redirect (one delay slot), and flush.
- Flags illegal fetch addresses (AdEL precursor) and delivers instruction, PC, valid and exception bits to D.

Parameters:
PC_RESET  32'h0000_3000  PC value after reset
IM_BASE   32'h0000_3000  lowest legal fetch address
IM_WORDS  4096           instruction-memory depth in words; legal range is IM_BASE .. IM_BASE+4*IM_WORDS-4

Ports:
clk            in   1   clock, all state on rising edge
reset          in   1   synchronous, active-low; reset==0 at a rising edge initialises the block
stall          in   1   hazard-unit stall: hold PC and F/D register
redirect       in   1   D-stage branch taken / jump resolved
redirect_pc    in   32  target for redirect
flush          in   1   kill F/D contents (exception/eret path)
flush_pc       in   32  PC to load on flush
im_addr        out  32  instruction-memory address (= F_pc)
im_rdata       in   32  instruction word, combinational from im_addr
F_pc           out  32  current fetch PC (trace)
F_instruction  out  32  instruction entering D next edge (0 if illegal)
D_pc           out  32  registered PC for decode
D_instruction  out  32  registered instruction for decode
D_valid        out  1   0 = bubble
D_exc_adel     out  1   fetch-address exception travels with D slot

Behaviour:
- Reset (reset==0 at edge), which overrides every other input:
  - F_pc=PC_RESET.
  - D_pc=0, D_instruction=0, D_valid=0, D_exc_adel=0.
- F_illegal = (F_pc[1:0]!=0) or F_pc<IM_BASE or F_pc>IM_BASE+4*IM_WORDS-4.
- F_instruction = F_illegal ? 0 : im_rdata. im_addr=F_pc always; memory contents are never read when F_illegal.
- Next-PC priority, per edge: reset > flush > stall > redirect > sequential.
  - flush: F_pc<=flush_pc; F/D <= bubble (instr 0, pc 0, valid 0, exc 0).
  - stall (flush=0): F_pc and all D_* hold. redirect is ignored because its operands are stale; the hazard unit re-asserts it after the stall drops.
  - redirect (no stall/flush): F_pc<=redirect_pc. F/D captures the current F slot, which is the delay slot and is never killed.
  - otherwise: F_pc<=F_pc+4, wrapping modulo 2^32. F/D captures F_pc, F_instruction, valid=1, exc=F_illegal.
- Latency: an instruction at F_pc appears on D_* exactly one edge after it is fetched, absent stall.
- Illegal fetch: the PC still advances normally, so the handler is reached only via flush. The exception slot carries instruction 0 (nop) and D_exc_adel=1.
- redirect_pc misaligned is not checked at redirect time; it is caught next cycle as F_illegal.
- Simultaneous events:
  - flush+stall: flush wins.
  - flush+redirect: flush_pc wins.
  - stall+redirect: hold.
- Reset asserted mid-stall or mid-redirect discards all pending state.
- No combinational path from stall/redirect/flush to D_* outputs; these inputs feed only the next-state logic.

Decomposition:
- Shared package/macros file holds:
  - PC_RESET, IM_BASE, IM_WORDS defaults
  - NOP word 32'h0
  - bubble field constants
  - F/D bundle field widths, reused by the D/E register
- One natural sub-module: fd_reg, a generic pipeline register with en (=~stall), clr (=flush) and bubble value. It is reused for D/E, E/M and M/W.
- PC register and legality check stay in fetch_stage.

Test Plan:
- Reset then free-run, im_rdata=addr-tagged words -> F_pc 0x3000, 0x3004, 0x3008 on successive edges; D_pc lags by one edge; D_valid=1 from second edge.
- stall=1 for 2 cycles at F_pc=0x3008 -> F_pc and D_pc (0x3004) frozen both cycles; resumes 0x300C then 0x3010.
- redirect=1, redirect_pc=0x3100 while F_pc=0x3010 -> next F_pc=0x3100; D_pc=0x3010 with valid=1 (delay slot kept).
- stall=1 with redirect=1 -> PC held; then redirect with stall=0 -> F_pc=redirect_pc on that edge.
- redirect_pc=0x3002, then 0x2FFC and 0x7000 -> each yields F_instruction=0 and D_exc_adel=1 next edge; legal 0x6FFC yields exc=0.
- flush=1 with stall=1 and redirect=1, flush_pc=0x4180 -> F_pc=0x4180, D_valid=0, D_instruction=0; reset==0 mid-stall -> F_pc=0x3000, all D_* cleared.
